wb_unit: RTL and testbench



---
 rtl/wb_unit_pkg.sv | 15 +
 rtl/wb_lq.sv | 66 ++++++
 rtl/wb_unit.sv | 88 ++++++++
 tb/tb_wb_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wb_unit_pkg.sv
// Shared write-back definitions: register-file geometry and the load-queue entry.
// Decode and execute import this package too.
package wb_unit_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } lq_entry_t;

endpackage

// File: rtl/wb_lq.sv
// In-order load-result FIFO. It exposes per-entry dest/valid vectors so that
// decode can search for pending writes.
module wb_lq
   import wb_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  lq_entry_t                      push_entry,
   input  logic                           pop,
   output logic                           full,
   output logic                           empty,
   output lq_entry_t                      head,
   output logic [DEPTH-1:0]               ent_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]   ent_dest
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   lq_entry_t              mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic                   do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; validity comes from the pointers and the count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_entry;
   end

   always_comb begin
      ent_valid = '0;
      ent_dest  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         logic [PTR_W-1:0] offset;
         offset       = PTR_W'(i) - rd_ptr_q;
         ent_valid[i] = ({1'b0, offset} < count_q);
         ent_dest[i]  = mem[i].dest;
      end
   end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage. It merges the never-stalling ALU path with the handshaked load
// path into a single register-file write port, and answers RAW-hazard queries.
module wb_unit #(
   parameter int unsigned DATA_W   = wb_unit_pkg::DATA_W,
   parameter int unsigned ADDR_W   = wb_unit_pkg::ADDR_W,
   parameter int unsigned LQ_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_dest,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_dest,
   input  logic [DATA_W-1:0] mem_data,
   output logic              regwrite,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] chk_reg,
   output logic              chk_pending
);

   import wb_unit_pkg::*;

   logic                             lq_full, lq_empty, lq_push, lq_pop;
   lq_entry_t                        lq_head, lq_in;
   logic [LQ_DEPTH-1:0]              lq_valid;
   logic [LQ_DEPTH-1:0][ADDR_W-1:0]  lq_dest;
   logic                             alu_wr, mem_wr, lq_hit;

   // Ready ignores a same-cycle pop, which keeps the path from ready to the pop logic short.
   assign mem_ready = !lq_full && !rst;
   assign alu_wr    = alu_valid && (alu_dest != REG_ZERO);
   assign mem_wr    = mem_valid && mem_ready && (mem_dest != REG_ZERO);

   assign lq_pop  = !alu_wr && !lq_empty;
   assign lq_push = mem_wr && (alu_wr || !lq_empty);
   assign lq_in   = '{dest: mem_dest, data: mem_data};

   wb_lq #(
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk        (clk),
      .rst        (rst),
      .push       (lq_push),
      .push_entry (lq_in),
      .pop        (lq_pop),
      .full       (lq_full),
      .empty      (lq_empty),
      .head       (lq_head),
      .ent_valid  (lq_valid),
      .ent_dest   (lq_dest)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else if (alu_wr) begin
         regwrite   <= 1'b1;
         write_reg  <= alu_dest;
         write_data <= alu_data;
      end else if (!lq_empty) begin
         regwrite   <= 1'b1;
         write_reg  <= lq_head.dest;
         write_data <= lq_head.data;
      end else if (mem_wr) begin
         regwrite   <= 1'b1;
         write_reg  <= mem_dest;
         write_data <= mem_data;
      end else begin
         regwrite   <= 1'b0;
      end
   end

   // The output-stage term matters because the register file reads before this commit lands.
   always_comb begin
      lq_hit = 1'b0;
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
         if (lq_valid[i] && (lq_dest[i] == chk_reg)) lq_hit = 1'b1;
      end
      chk_pending = !rst && (chk_reg != REG_ZERO) &&
                    (lq_hit || (regwrite && (write_reg == chk_reg)));
   end

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios followed by random traffic, all checked every cycle
// against a queue-based model of the write-back rules.
module tb_wb_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } load_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid, mem_ready;
   logic [AW-1:0] alu_dest, mem_dest, write_reg, chk_reg;
   logic [DW-1:0] alu_data, mem_data, write_data;
   logic          regwrite, chk_pending;

   int passed = 0;
   int total  = 0;

   // Model state
   load_t         mq[$];
   logic          m_rw;
   logic [AW-1:0] m_wr;
   logic [DW-1:0] m_wd;

   always #5 clk = ~clk;

   wb_unit #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .LQ_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_dest    (alu_dest),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_dest    (mem_dest),
      .mem_data    (mem_data),
      .regwrite    (regwrite),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .chk_reg     (chk_reg),
      .chk_pending (chk_pending)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic model_ready();
      return !rst && (mq.size() < DEPTH);
   endfunction

   function automatic logic model_pending(input logic [AW-1:0] r);
      logic hit;
      hit = 1'b0;
      if (rst || r == 0) return 1'b0;
      foreach (mq[i]) if (mq[i].dest == r) hit = 1'b1;
      if (m_rw && m_wr == r) hit = 1'b1;
      return hit;
   endfunction

   // Drive one cycle of inputs, check the combinational outputs before the edge and the
   // registered outputs after it.
   task automatic cycle(input logic r, input logic av, input logic [AW-1:0] ad,
                        input logic [DW-1:0] adat, input logic mv, input logic [AW-1:0] md,
                        input logic [DW-1:0] mdat, input logic [AW-1:0] ck);
      logic  rdy, hs;
      load_t ld;
      rst = r; alu_valid = av; alu_dest = ad; alu_data = adat;
      mem_valid = mv; mem_dest = md; mem_data = mdat; chk_reg = ck;
      #1;
      rdy = model_ready();
      check("mem_ready", mem_ready, rdy);
      check("chk_pending", chk_pending, model_pending(ck));
      hs = mv && rdy;
      ld.dest = md; ld.data = mdat;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_rw = 0; m_wr = 0; m_wd = 0;
      end else if (av && ad != 0) begin
         m_rw = 1; m_wr = ad; m_wd = adat;
         if (hs && md != 0) mq.push_back(ld);
      end else if (mq.size() > 0) begin
         load_t h;
         h = mq.pop_front();
         m_rw = 1; m_wr = h.dest; m_wd = h.data;
         if (hs && md != 0) mq.push_back(ld);
      end else if (hs && md != 0) begin
         m_rw = 1; m_wr = md; m_wd = mdat;
      end else begin
         m_rw = 0;
      end
      #1;
      check("regwrite", regwrite, m_rw);
      check("write_reg", write_reg, m_wr);
      check("write_data", write_data, m_wd);
      @(negedge clk);
   endtask

   task automatic idle(input logic [AW-1:0] ck);
      cycle(0, 0, 0, 0, 0, 0, 0, ck);
   endtask

   initial begin
      m_rw = 0; m_wr = 0; m_wd = 0;
      rst = 1; alu_valid = 0; alu_dest = 0; alu_data = 0;
      mem_valid = 0; mem_dest = 0; mem_data = 0; chk_reg = 0;
      @(negedge clk);

      // Reset held for two cycles while ALU traffic is offered
      cycle(1, 1, 3, 32'hdead, 1, 4, 32'h1, 3);
      cycle(1, 1, 3, 32'hdead, 1, 4, 32'h1, 3);
      check("reset_regwrite", regwrite, 1'b0);
      check("reset_write_reg", write_reg, 5'd0);
      idle(0);
      check("ready_after_reset", mem_ready, 1'b1);

      // ALU write with one-cycle latency; the output holds afterwards
      cycle(0, 1, 5, 32'h1234, 0, 0, 0, 5);
      check("alu_pulse", regwrite, 1'b1);
      idle(5);
      check("alu_hold_reg", write_reg, 5'd5);

      // Writes to register zero are discarded
      cycle(0, 1, 0, 32'd20, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 32'd30, 0);
      check("r0_no_write", regwrite, 1'b0);
      idle(0);

      // ALU contention: two loads queue up and ready drops
      cycle(0, 1, 1, 32'ha, 1, 2, 32'hb, 2);
      cycle(0, 1, 1, 32'ha, 1, 3, 32'hc, 3);
      cycle(0, 1, 1, 32'ha, 0, 0, 0, 2);
      cycle(0, 0, 0, 0, 0, 0, 0, 3);
      check("r2_commit", write_reg, 5'd2);
      cycle(0, 0, 0, 0, 0, 0, 0, 3);
      check("r3_commit", write_reg, 5'd3);
      idle(3);

      // Hazard query on loads held behind ALU traffic
      cycle(0, 1, 1, 32'h11, 1, 7, 32'h77, 8);
      cycle(0, 1, 1, 32'h12, 1, 8, 32'h88, 8);
      cycle(0, 1, 1, 32'h13, 0, 0, 0, 8);
      cycle(0, 0, 0, 0, 0, 0, 0, 9);
      cycle(0, 0, 0, 0, 0, 0, 0, 8);
      cycle(0, 0, 0, 0, 0, 0, 0, 8);
      idle(8);

      // Reset while the FIFO holds r4 and r6
      cycle(0, 1, 1, 32'h21, 1, 4, 32'h44, 4);
      cycle(0, 1, 1, 32'h22, 1, 6, 32'h66, 6);
      cycle(1, 0, 0, 0, 0, 0, 0, 4);
      cycle(0, 0, 0, 0, 0, 0, 0, 4);
      check("no_r4_after_reset", regwrite, 1'b0);
      cycle(0, 0, 0, 0, 0, 0, 0, 6);
      idle(4);

      // Random traffic, small register range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 1) == 0), AW'($urandom_range(0, 7)), $urandom,
               AW'($urandom_range(0, 7)));
      end
      for (int i = 0; i < 4; i++) idle(AW'(i));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
